// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / taken-branch / multi-cycle EX hazard sequencer for the 5-stage pipeline,
// with saturating stall and flush performance counters.
module hazard_control_unit #(
    parameter int MC_LATENCY = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ID_EX_MemRead,
    input  logic [4:0]  i_ID_EX_rd,
    input  logic [4:0]  i_IF_ID_rs1,
    input  logic [4:0]  i_IF_ID_rs2,
    input  logic        i_IF_ID_uses_rs2,
    input  logic        i_branch_taken,
    input  logic        i_ID_EX_multicycle,
    output logic        o_PC_Write,
    output logic        o_IF_ID_Write,
    output logic        o_flush,
    output logic        o_ID_EX_bubble,
    output logic        o_ID_EX_hold,
    output logic        o_EX_MEM_bubble,
    output logic        o_mc_busy,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MC_STALL = 2'd1;
    localparam logic [1:0] S_MC_DONE  = 2'd2;
    localparam bit         MC_EN      = MC_LATENCY >= 2;
    localparam bit         MC_LONG    = MC_LATENCY >= 3;
    localparam logic [3:0] MC_INIT    = MC_LONG ? 4'(MC_LATENCY - 2) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_lu;
    logic        w_in_stall;
    logic        w_br;
    logic        w_mc_start;
    logic        w_mc;
    logic        w_lu_stall;

    // Priority: taken branch, then starting a multi-cycle op (RUN only), then load-use.
    always_comb begin
        w_lu       = i_ID_EX_MemRead && (i_ID_EX_rd != 5'd0) &&
                     ((i_ID_EX_rd == i_IF_ID_rs1) || (i_IF_ID_uses_rs2 && (i_ID_EX_rd == i_IF_ID_rs2)));
        w_in_stall = r_state == S_MC_STALL;
        w_br       = !w_in_stall && i_branch_taken;
        w_mc_start = MC_EN && (r_state == S_RUN) && i_ID_EX_multicycle && !i_branch_taken;
        w_mc       = w_in_stall || w_mc_start;
        w_lu_stall = !w_mc && !w_br && w_lu;
    end

    assign o_PC_Write      = i_reset && !w_mc && !w_lu_stall;
    assign o_IF_ID_Write   = !i_reset || w_br || w_mc || w_lu_stall;
    assign o_flush         = !i_reset || w_br;
    assign o_ID_EX_bubble  = !i_reset || w_br || w_lu_stall;
    assign o_ID_EX_hold    = i_reset && w_mc;
    assign o_EX_MEM_bubble = !i_reset || w_mc;
    assign o_mc_busy       = i_reset && w_mc;
    assign o_stall_cycles  = r_stall_cycles;
    assign o_flush_count   = r_flush_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_RUN;
            r_cnt          <= 4'd0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (w_in_stall) begin
                r_cnt   <= r_cnt - 4'd1;
                r_state <= (r_cnt == 4'd1) ? S_MC_DONE : S_MC_STALL;
            end else if (w_mc_start) begin
                r_cnt   <= MC_INIT;
                r_state <= MC_LONG ? S_MC_STALL : S_MC_DONE;
            end else begin
                r_state <= S_RUN;
            end
            if (!o_PC_Write && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_br && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and randomized checks of three hazard_control_unit instances
// (MC_LATENCY 4, 2, 1) sharing one stimulus, against a cycle-age reference model.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, memread, uses, br, mc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  pc_w, ifid_w, fl, bub, hold, exb, busy;
    logic [31:0] sc [3];
    logic [31:0] fc [3];
    logic [6:0]  obs [3];
    int          checks = 0;
    int          failures = 0;
    int          age [3];
    longint      msc [3];
    longint      mfc [3];

    // Output vector order: {PC_Write, IF_ID_Write, flush, ID_EX_bubble, ID_EX_hold, EX_MEM_bubble, mc_busy}
    localparam logic [6:0] O_IDLE = 7'b1000000;
    localparam logic [6:0] O_RST  = 7'b0111010;
    localparam logic [6:0] O_MC   = 7'b0100111;
    localparam logic [6:0] O_BR   = 7'b1111000;
    localparam logic [6:0] O_LU   = 7'b0101000;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_control_unit #(.MC_LATENCY(g == 0 ? 4 : (g == 1 ? 2 : 1))) dut (
            .i_clk             (clk),
            .i_reset           (rst_n),
            .i_ID_EX_MemRead   (memread),
            .i_ID_EX_rd        (rd),
            .i_IF_ID_rs1       (rs1),
            .i_IF_ID_rs2       (rs2),
            .i_IF_ID_uses_rs2  (uses),
            .i_branch_taken    (br),
            .i_ID_EX_multicycle(mc),
            .o_PC_Write        (pc_w[g]),
            .o_IF_ID_Write     (ifid_w[g]),
            .o_flush           (fl[g]),
            .o_ID_EX_bubble    (bub[g]),
            .o_ID_EX_hold      (hold[g]),
            .o_EX_MEM_bubble   (exb[g]),
            .o_mc_busy         (busy[g]),
            .o_stall_cycles    (sc[g]),
            .o_flush_count     (fc[g])
        );
        assign obs[g] = {pc_w[g], ifid_w[g], fl[g], bub[g], hold[g], exb[g], busy[g]};
    end

    function automatic int lat(int k);
        return k == 0 ? 4 : (k == 1 ? 2 : 1);
    endfunction

    function automatic bit lu_now();
        return memread && (rd != 5'd0) && ((rd == rs1) || (uses && (rd == rs2)));
    endfunction

    // age = cycles the multi-cycle op has already spent in EX (0 = none); its last EX cycle does not stall.
    function automatic bit mc_stall(int k);
        return (age[k] > 0 && age[k] < lat(k) - 1) || (age[k] == 0 && mc && !br && lat(k) >= 2);
    endfunction

    function automatic logic [6:0] exp_out(int k);
        if (!rst_n) return O_RST;
        if (mc_stall(k)) return O_MC;
        if (br) return O_BR;
        if (lu_now()) return O_LU;
        return O_IDLE;
    endfunction

    task automatic tick();
        logic [6:0] e;
        bit st;
        for (int k = 0; k < 3; k++) begin
            e  = exp_out(k);
            st = mc_stall(k);
            if (!rst_n) begin
                age[k] = 0;
                msc[k] = 0;
                mfc[k] = 0;
            end else begin
                if (!e[6] && msc[k] < 64'hFFFF_FFFF) msc[k]++;
                if (e[4] && mfc[k] < 64'hFFFF_FFFF) mfc[k]++;
                age[k] = (age[k] == 0) ? (st ? 1 : 0) : (age[k] < lat(k) - 1 ? age[k] + 1 : 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1'b1; memread = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; uses = 1'b0; br = 1'b0; mc = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== O_RST) begin failures++; $display("FAIL reset_outputs[%0d] got=%b exp=%b", k, obs[k], O_RST); end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== O_IDLE) begin failures++; $display("FAIL post_reset_idle[%0d] got=%b exp=%b", k, obs[k], O_IDLE); end
            checks++;
            if (sc[k] !== 32'd0 || fc[k] !== 32'd0) begin failures++; $display("FAIL post_reset_counters[%0d] got=%0d/%0d exp=0/0", k, sc[k], fc[k]); end
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", obs[0], O_LU); end
        tick();
        memread = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_IDLE) begin failures++; $display("FAIL lu_cleared got=%b exp=%b", obs[0], O_IDLE); end
        checks++;
        if (sc[0] !== 32'd1) begin failures++; $display("FAIL lu_stall_count got=%0d exp=1", sc[0]); end
        tick();
        memread = 1'b1; rd = 5'd0; rs1 = 5'd0;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_IDLE) begin failures++; $display("FAIL lu_rd_zero got=%b exp=%b", obs[0], O_IDLE); end
        tick();
        rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; uses = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_IDLE) begin failures++; $display("FAIL lu_rs2_unused got=%b exp=%b", obs[0], O_IDLE); end
        tick();
        uses = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_LU) begin failures++; $display("FAIL lu_rs2_used got=%b exp=%b", obs[0], O_LU); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (sc[0] !== 32'd2) begin failures++; $display("FAIL lu_stall_count2 got=%0d exp=2", sc[0]); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; br = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_BR) begin failures++; $display("FAIL branch_over_lu got=%b exp=%b", obs[0], O_BR); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (fc[0] !== 32'd1) begin failures++; $display("FAIL branch_flush_count got=%0d exp=1", fc[0]); end
        checks++;
        if (sc[0] !== 32'd0) begin failures++; $display("FAIL branch_stall_count got=%0d exp=0", sc[0]); end
        tick();
    endtask

    task automatic test_multicycle();
        logic [6:0] tab [3][4] = '{'{O_MC, O_MC, O_MC, O_IDLE},
                                   '{O_MC, O_BR, O_MC, O_IDLE},
                                   '{O_IDLE, O_BR, O_IDLE, O_IDLE}};
        logic [31:0] exp_sc [3] = '{32'd3, 32'd2, 32'd0};
        logic [31:0] exp_fc [3] = '{32'd0, 32'd1, 32'd1};
        do_reset();
        mc = 1'b1;
        for (int c = 0; c < 4; c++) begin
            br = (c == 1);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== tab[k][c]) begin failures++; $display("FAIL mc_seq[lat=%0d,cyc=%0d] got=%b exp=%b", lat(k), c, obs[k], tab[k][c]); end
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sc[k] !== exp_sc[k] || fc[k] !== exp_fc[k]) begin
                failures++;
                $display("FAIL mc_counters[lat=%0d] got=%0d/%0d exp=%0d/%0d", lat(k), sc[k], fc[k], exp_sc[k], exp_fc[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mc = 1'b1;
        @(negedge clk);
        tick();
        mc = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_RST) begin failures++; $display("FAIL reset_in_stall got=%b exp=%b", obs[0], O_RST); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_IDLE) begin failures++; $display("FAIL reset_aborts_stall got=%b exp=%b", obs[0], O_IDLE); end
        checks++;
        if (sc[0] !== 32'd0 || fc[0] !== 32'd0) begin failures++; $display("FAIL reset_mid_counters got=%0d/%0d exp=0/0", sc[0], fc[0]); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        repeat (500) begin
            rst_n   = $urandom_range(0, 39) != 0;
            memread = 1'($urandom_range(0, 1));
            rd      = 5'($urandom_range(0, 3));
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            uses    = 1'($urandom_range(0, 1));
            br      = $urandom_range(0, 5) == 0;
            mc      = $urandom_range(0, 2) == 0;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin failures++; $display("FAIL rand_outputs[lat=%0d] got=%b exp=%b", lat(k), obs[k], exp_out(k)); end
                checks++;
                if (sc[k] !== 32'(msc[k])) begin failures++; $display("FAIL rand_stall_cycles[lat=%0d] got=%0d exp=%0d", lat(k), sc[k], msc[k]); end
                checks++;
                if (fc[k] !== 32'(mfc[k])) begin failures++; $display("FAIL rand_flush_count[lat=%0d] got=%0d exp=%0d", lat(k), fc[k], mfc[k]); end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force g_dut[0].dut.r_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release g_dut[0].dut.r_stall_cycles;
        #1;
        checks++;
        if (sc[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_preload got=%h exp=ffffffff", sc[0]); end
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
        #1;
        checks++;
        if (obs[0] !== O_LU) begin failures++; $display("FAIL sat_lu got=%b exp=%b", obs[0], O_LU); end
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        checks++;
        if (sc[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffffffff", sc[0]); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            age[k] = 0; msc[k] = 0; mfc[k] = 0;
        end
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
